// File: rtl/param_serializer_fsm_if.sv
// Bundle of the serializer's control, data and status signals.
//
// Handshake: there is no ready back-pressure. The producer raises `start`
// with `data_input` valid; the word is taken only on a rising edge where
// the serializer is idle (`busy`=0). `start` seen while busy is dropped,
// not queued. `ss` is an asynchronous active-low select: its falling edge
// launches a loaded frame, its rising edge mid-frame drops the frame.
// `data_sent` and `aborted` are single-cycle status pulses.
interface param_serializer_fsm_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic             ss;
  logic [WIDTH-1:0] data_input;
  logic             data_output;
  logic             data_sent;
  logic             busy;
  logic             aborted;

  modport master (
    output start, ss, data_input,
    input  data_output, data_sent, busy, aborted
  );

  modport slave (
    input  start, ss, data_input,
    output data_output, data_sent, busy, aborted
  );
endinterface

// File: rtl/param_serializer_fsm.sv
// Parametrised N-to-1 serializer: load a word on start, wait for ss to fall,
// shift it out one bit per CLK_DIV clocks, abort if ss rises mid-frame.
module param_serializer_fsm #(
  parameter int WIDTH      = 14,
  parameter int CLK_DIV    = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  param_serializer_fsm_if.slave bus,
  output logic [2:0]            o_dbg_state
);

  localparam int BCW = $clog2(WIDTH);
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state, w_next_state;
  logic             r_ss_q1, r_ss_q2, r_ss_q3;
  logic [WIDTH-1:0] r_shift, w_next_shift;
  logic [BCW-1:0]   r_bit_cnt, w_next_bit_cnt;
  logic [DVW-1:0]   r_div, w_next_div;
  logic             r_data_output, w_next_data_output;
  logic             r_data_sent;
  logic             r_aborted, w_abort;
  logic             w_fall, w_rise;

  // Two-flop synchroniser plus a history flop for edge detection on ss.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ss_q1 <= 1'b1;
      r_ss_q2 <= 1'b1;
      r_ss_q3 <= 1'b1;
    end else begin
      r_ss_q1 <= bus.ss;
      r_ss_q2 <= r_ss_q1;
      r_ss_q3 <= r_ss_q2;
    end
  end

  assign w_fall = r_ss_q3 & ~r_ss_q2;
  assign w_rise = ~r_ss_q3 & r_ss_q2;

  // Next-state, datapath and next-output decode; abort outranks shifting.
  always_comb begin
    w_next_state   = r_state;
    w_next_shift   = r_shift;
    w_next_bit_cnt = r_bit_cnt;
    w_next_div     = r_div;
    w_abort        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_shift = bus.data_input;
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: w_next_state = S_WAIT;
      S_WAIT: begin
        if (w_fall) begin
          w_next_state   = S_SEND;
          w_next_bit_cnt = '0;
          w_next_div     = '0;
        end
      end
      S_SEND: begin
        if (w_rise) begin
          w_next_state = S_IDLE;
          w_abort      = 1'b1;
        end else if (r_div == DIV_LAST) begin
          w_next_div   = '0;
          w_next_shift = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shift[WIDTH-1:1]};
          if (r_bit_cnt == BIT_LAST) begin
            // Counter holds at its last value rather than wrapping.
            w_next_state = S_DONE;
          end else begin
            w_next_bit_cnt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_next_div = r_div + 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase

    w_next_data_output = IDLE_LEVEL;
    if (w_next_state == S_SEND) begin
      w_next_data_output = MSB_FIRST ? w_next_shift[WIDTH-1] : w_next_shift[0];
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_div         <= '0;
      r_data_output <= IDLE_LEVEL;
      r_data_sent   <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_shift       <= w_next_shift;
      r_bit_cnt     <= w_next_bit_cnt;
      r_div         <= w_next_div;
      r_data_output <= w_next_data_output;
      r_data_sent   <= (w_next_state == S_DONE);
      r_aborted     <= w_abort;
    end
  end

  assign bus.data_output = r_data_output;
  assign bus.data_sent   = r_data_sent;
  assign bus.aborted     = r_aborted;
  assign bus.busy        = (r_state != S_IDLE);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_param_serializer_fsm.sv
// Directed bench for param_serializer_fsm: two instances with different
// bit period, bit order and idle level share one clock and reset.
module tb_param_serializer_fsm;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_a;
  logic [2:0] dbg_b;
  int         checks;
  int         errors;

  // Expected serial streams for 14'h2A5B, first transmitted bit leftmost.
  logic [13:0] seq_msb;
  logic [13:0] seq_lsb;

  param_serializer_fsm_if #(.WIDTH(14)) bus_a ();
  param_serializer_fsm_if #(.WIDTH(14)) bus_b ();

  param_serializer_fsm #(
    .WIDTH(14), .CLK_DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) dut_a (
    .i_clock    (clk),
    .i_reset    (rst),
    .bus        (bus_a),
    .o_dbg_state(dbg_a)
  );

  param_serializer_fsm #(
    .WIDTH(14), .CLK_DIV(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .i_clock    (clk),
    .i_reset    (rst),
    .bus        (bus_b),
    .o_dbg_state(dbg_b)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    seq_msb = 14'b10101001011011;
    seq_lsb = 14'b11011010010101;

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.ss = 1'b1; bus_a.data_input = '0;
    bus_b.start = 1'b0; bus_b.ss = 1'b1; bus_b.data_input = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state with ss held high
    chk1("rst_a_dout", bus_a.data_output, 1'b0);
    chk1("rst_a_busy", bus_a.busy, 1'b0);
    chk1("rst_a_sent", bus_a.data_sent, 1'b0);
    chk1("rst_a_abrt", bus_a.aborted, 1'b0);
    chk1("rst_b_dout", bus_b.data_output, 1'b1);
    repeat (4) tick();
    chk3("idle_a_state", dbg_a, ST_IDLE);
    chk1("idle_a_busy", bus_a.busy, 1'b0);
    chk3("idle_b_state", dbg_b, ST_IDLE);

    // Frame on A: 2A5B, MSB first, one clock per bit
    bus_a.start = 1'b1; bus_a.data_input = 14'h2A5B;
    tick();
    bus_a.start = 1'b0; bus_a.data_input = 14'h0000;
    chk3("a1_load", dbg_a, ST_LOAD);
    chk1("a1_busy", bus_a.busy, 1'b1);
    tick();
    chk3("a1_wait", dbg_a, ST_WAIT);
    bus_a.ss = 1'b0;
    tick();
    tick();
    chk3("a1_wait_lat", dbg_a, ST_WAIT);
    chk1("a1_wait_dout", bus_a.data_output, 1'b0);
    tick();
    chk3("a1_send", dbg_a, ST_SEND);
    for (int i = 0; i < 14; i++) begin
      chk1($sformatf("a1_bit%0d", i), bus_a.data_output, seq_msb[13-i]);
      chk1($sformatf("a1_nosent%0d", i), bus_a.data_sent, 1'b0);
      tick();
    end
    chk3("a1_done", dbg_a, ST_DONE);
    chk1("a1_sent", bus_a.data_sent, 1'b1);
    chk1("a1_done_dout", bus_a.data_output, 1'b0);
    bus_a.start = 1'b1; bus_a.data_input = 14'h0F0F;
    tick();
    chk1("a1_sent_once", bus_a.data_sent, 1'b0);
    chk1("a1_busy_low", bus_a.busy, 1'b0);
    bus_a.start = 1'b0;
    bus_a.ss = 1'b1;
    repeat (3) tick();
    chk3("a1_start_in_done_ignored", dbg_a, ST_IDLE);

    // Frame on B: LSB first, 3 clocks per bit, idle level 1, with ignored starts
    bus_b.start = 1'b1; bus_b.data_input = 14'h2A5B;
    tick();
    bus_b.start = 1'b0;
    chk3("b_load", dbg_b, ST_LOAD);
    tick();
    bus_b.start = 1'b1; bus_b.data_input = 14'h1234;
    tick();
    chk3("b_wait_ignores_start", dbg_b, ST_WAIT);
    chk1("b_wait_dout", bus_b.data_output, 1'b1);
    bus_b.start = 1'b0; bus_b.data_input = 14'h0000;
    bus_b.ss = 1'b0;
    repeat (3) tick();
    chk3("b_send", dbg_b, ST_SEND);
    for (int i = 0; i < 14; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk1($sformatf("b_bit%0d_%0d", i, j), bus_b.data_output, seq_lsb[13-i]);
        bus_b.start = (i == 4 && j == 1);
        bus_b.data_input = (i == 4 && j == 1) ? 14'h3C3C : 14'h0000;
        tick();
      end
    end
    bus_b.start = 1'b0;
    chk3("b_done", dbg_b, ST_DONE);
    chk1("b_sent", bus_b.data_sent, 1'b1);
    chk1("b_done_dout", bus_b.data_output, 1'b1);
    tick();
    chk1("b_busy_low", bus_b.busy, 1'b0);
    chk1("b_sent_low", bus_b.data_sent, 1'b0);
    bus_b.ss = 1'b1;

    // Abort on A after 5 bits
    bus_a.start = 1'b1; bus_a.data_input = 14'h2A5B;
    tick();
    bus_a.start = 1'b0;
    tick();
    bus_a.ss = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("ab_bit%0d", i), bus_a.data_output, seq_msb[13-i]);
      tick();
    end
    chk1("ab_bit5", bus_a.data_output, seq_msb[8]);
    bus_a.ss = 1'b1;
    tick();
    chk1("ab_bit6", bus_a.data_output, seq_msb[7]);
    tick();
    chk3("ab_still_send", dbg_a, ST_SEND);
    chk1("ab_bit7", bus_a.data_output, seq_msb[6]);
    tick();
    chk3("ab_idle", dbg_a, ST_IDLE);
    chk1("ab_aborted", bus_a.aborted, 1'b1);
    chk1("ab_busy", bus_a.busy, 1'b0);
    chk1("ab_dout", bus_a.data_output, 1'b0);
    chk1("ab_nosent", bus_a.data_sent, 1'b0);
    tick();
    chk1("ab_aborted_once", bus_a.aborted, 1'b0);

    // Next start accepted normally; reset lands at bit 7
    bus_a.start = 1'b1; bus_a.data_input = 14'h2A5B;
    tick();
    bus_a.start = 1'b0;
    chk3("rs_load", dbg_a, ST_LOAD);
    tick();
    bus_a.ss = 1'b0;
    repeat (3) tick();
    repeat (7) tick();
    chk1("rs_bit7", bus_a.data_output, seq_msb[6]);
    rst = 1'b1;
    bus_a.ss = 1'b1;
    tick();
    chk3("rs_state", dbg_a, ST_IDLE);
    chk1("rs_dout", bus_a.data_output, 1'b0);
    chk1("rs_busy", bus_a.busy, 1'b0);
    chk1("rs_sent", bus_a.data_sent, 1'b0);
    chk1("rs_abrt", bus_a.aborted, 1'b0);
    rst = 1'b0;
    repeat (3) tick();

    // All-ones frame after reset
    bus_a.start = 1'b1; bus_a.data_input = 14'h3FFF;
    tick();
    bus_a.start = 1'b0;
    tick();
    bus_a.ss = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 14; i++) begin
      chk1($sformatf("ff_bit%0d", i), bus_a.data_output, 1'b1);
      tick();
    end
    chk1("ff_sent", bus_a.data_sent, 1'b1);
    chk1("ff_dout", bus_a.data_output, 1'b0);
    tick();
    chk1("ff_busy", bus_a.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
